// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the MiniTinyMIPS multi-cycle controller: state codes,
// opcode/funct values, ALU class encodings and datapath mux selector codes.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_RWB    = 4'd8,
        ST_IEXEC  = 4'd9,
        ST_IWB    = 4'd10,
        ST_HALT   = 4'd11,
        ST_BR     = 4'd12,
        ST_JMP    = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_SUB   = 5'b01000;
    localparam logic [4:0] ALU_FUNCT = 5'b10000;
    localparam logic [4:0] ALU_OR    = 5'b00100;
    localparam logic [4:0] ALU_LUI   = 5'b00010;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REGA   = 2'b11;

    function automatic logic [4:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OP_ORI:  return ALU_OR;
            OP_LUI:  return ALU_LUI;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles spent waiting on a memory handshake and flags the
// cycle in which the wait reaches LIMIT without the handshake completing.
module mem_wait_timer #(
    parameter int LIMIT = 16,
    parameter int W     = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry is only meaningful while still waiting, so a handshake in the limit cycle wins.
    assign expired_o = enable_i && !clear_i && (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MiniTinyMIPS core: sequences fetch,
// decode, execute, memory and writeback and drives the datapath controls.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int RESET_PC_HOLD  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [4:0] alu_ct_op,
    output logic       illegal_instr,
    output logic       bus_err,
    output logic [3:0] state_dbg
);

    state_e     state_q, state_d;
    logic [3:0] hold_q, hold_d;
    logic [5:0] op_q, op_d;
    logic       illegal_q, illegal_d;
    logic       bus_err_q, bus_err_d;
    logic       waiting, timer_clear, timer_enable, timer_expired;

    assign waiting      = (state_q == ST_FETCH) || (state_q == ST_MEMRD) || (state_q == ST_MEMWR);
    assign timer_enable = waiting && !mem_ready;
    assign timer_clear  = !waiting || mem_ready;

    mem_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     (8)
    ) u_timer (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .clear_i   (timer_clear),
        .enable_i  (timer_enable),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        op_d          = op_q;
        illegal_d     = illegal_q;
        bus_err_d     = bus_err_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        pc_source     = PCSRC_ALU;
        alu_ct_op     = ALU_ADD;

        case (state_q)
            ST_IDLE: begin
                if (hold_q == 4'(RESET_PC_HOLD - 1)) begin
                    state_d = ST_FETCH;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_ct_op = ALU_ADD;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    pc_source = PCSRC_ALU;
                    state_d   = ST_DECODE;
                end else if (timer_expired) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded.
                alu_src_b = SRCB_IMM_SH2;
                alu_ct_op = ALU_ADD;
                op_d      = opcode;
                case (opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE: begin
                        if (funct == FN_JR) begin
                            pc_write  = 1'b1;
                            pc_source = PCSRC_REGA;
                            state_d   = ST_FETCH;
                        end else begin
                            state_d = ST_EXEC;
                        end
                    end
                    OP_BEQ:                   state_d = ST_BR;
                    OP_J:                     state_d = ST_JMP;
                    OP_ORI, OP_ADDIU, OP_LUI: state_d = ST_IEXEC;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = ST_HALT;
                    end
                endcase
            end
            ST_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_ct_op = ALU_ADD;
                state_d   = (op_q == OP_SW) ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) begin
                    state_d = ST_MEMWB;
                end else if (timer_expired) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_MEMWR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    state_d = ST_FETCH;
                end else if (timer_expired) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_B;
                alu_ct_op = ALU_FUNCT;
                state_d   = ST_RWB;
            end
            ST_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_ct_op = imm_alu_op(op_q);
                state_d   = ST_IWB;
            end
            ST_IWB: begin
                reg_write = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_BR: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_B;
                alu_ct_op     = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                state_d       = ST_FETCH;
            end
            ST_JMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                state_d   = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            op_q      <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign illegal_instr = illegal_q;
    assign bus_err       = bus_err_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: an instruction-level model expands each instruction into
// its expected per-cycle control outputs, compared against the DUT every cycle.
module tb_multicycle_ctrl;

    localparam int TIMEOUT = 16;
    localparam int HOLD    = 1;

    localparam int CL_LW = 0, CL_SW = 1, CL_R = 2, CL_BEQ = 3, CL_J = 4;
    localparam int CL_JR = 5, CL_ORI = 6, CL_ADDIU = 7, CL_LUI = 8, CL_ILL = 9;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [4:0] alu_ct_op;
        logic       illegal_instr;
        logic       bus_err;
        logic [3:0] state_dbg;
    } outs_t;

    typedef struct packed {
        logic [5:0] opcode;
        logic [5:0] funct;
        logic       ready;
        outs_t      exp;
    } cyc_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_instr, bus_err;
    logic [1:0] alu_src_b, pc_source;
    logic [4:0] alu_ct_op;
    logic [3:0] state_dbg;
    outs_t      dutOut;

    cyc_t plan[$];
    bit   stickyIll, stickyBus, halted;
    int   testsRun, testsFailed;
    int   cntMemWb, cntMemRead, cntIrWrite, cntMemWrite, cntPwc;

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .RESET_PC_HOLD  (HOLD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct         (funct),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .alu_ct_op     (alu_ct_op),
        .illegal_instr (illegal_instr),
        .bus_err       (bus_err),
        .state_dbg     (state_dbg)
    );

    assign dutOut = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
                     alu_ct_op, illegal_instr, bus_err, state_dbg};

    function automatic bit isLegal(logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                          6'b001101, 6'b001001, 6'b001111};
    endfunction

    function automatic outs_t blank(int st);
        outs_t o = '0;
        o.state_dbg     = 4'(st);
        o.illegal_instr = stickyIll;
        o.bus_err       = stickyBus;
        return o;
    endfunction

    task automatic push(logic [5:0] op, logic [5:0] fn, logic rdy, outs_t e);
        cyc_t c;
        c.opcode = op;
        c.funct  = fn;
        c.ready  = rdy;
        c.exp    = e;
        plan.push_back(c);
    endtask

    // A memory wait phase: waitCycles idle cycles then the ready cycle, unless the limit hits first.
    task automatic addWait(int st, logic [5:0] op, logic [5:0] fn, int waitCycles, output bit timedOut);
        outs_t o;
        timedOut = 1'b0;
        for (int k = 0; k <= waitCycles; k++) begin
            logic rdy;
            rdy = (k == waitCycles);
            o = blank(st);
            if (st == 1) begin
                o.mem_read  = 1'b1;
                o.alu_src_b = 2'b01;
                if (rdy) begin
                    o.ir_write = 1'b1;
                    o.pc_write = 1'b1;
                end
            end else begin
                o.i_or_d = 1'b1;
                if (st == 4) o.mem_read = 1'b1;
                else         o.mem_write = 1'b1;
            end
            push(op, fn, rdy, o);
            if (!rdy && k == TIMEOUT - 1) begin
                timedOut  = 1'b1;
                stickyBus = 1'b1;
                return;
            end
        end
    endtask

    task automatic addInstr(int cls, int fw, int mw, logic [5:0] fnR, logic [5:0] illOp);
        logic [5:0] op, fn;
        outs_t      o;
        bit         to;
        if (halted) return;
        fn = 6'($urandom);
        case (cls)
            CL_LW:    op = 6'b100011;
            CL_SW:    op = 6'b101011;
            CL_R:     begin op = 6'b000000; fn = (fnR == 6'b001000) ? 6'b100001 : fnR; end
            CL_BEQ:   op = 6'b000100;
            CL_J:     op = 6'b000010;
            CL_JR:    begin op = 6'b000000; fn = 6'b001000; end
            CL_ORI:   op = 6'b001101;
            CL_ADDIU: op = 6'b001001;
            CL_LUI:   op = 6'b001111;
            default: begin
                op = illOp;
                while (isLegal(op)) op = 6'($urandom);
            end
        endcase
        addWait(1, op, fn, fw, to);
        if (to) begin halted = 1'b1; return; end
        o = blank(2);
        o.alu_src_b = 2'b11;
        if (cls == CL_JR) begin
            o.pc_write  = 1'b1;
            o.pc_source = 2'b11;
        end
        push(op, fn, 1'($urandom), o);
        if (cls == CL_JR) return;
        if (cls == CL_ILL) begin
            stickyIll = 1'b1;
            halted    = 1'b1;
            return;
        end
        case (cls)
            CL_LW, CL_SW: begin
                o = blank(3);
                o.alu_src_a = 1'b1;
                o.alu_src_b = 2'b10;
                push(op, fn, 1'($urandom), o);
                addWait((cls == CL_LW) ? 4 : 6, op, fn, mw, to);
                if (to) begin halted = 1'b1; return; end
                if (cls == CL_LW) begin
                    o = blank(5);
                    o.reg_write  = 1'b1;
                    o.mem_to_reg = 1'b1;
                    push(op, fn, 1'($urandom), o);
                end
            end
            CL_R: begin
                o = blank(7);
                o.alu_src_a = 1'b1;
                o.alu_ct_op = 5'b10000;
                push(op, fn, 1'($urandom), o);
                o = blank(8);
                o.reg_write = 1'b1;
                o.reg_dst   = 1'b1;
                push(op, fn, 1'($urandom), o);
            end
            CL_BEQ: begin
                o = blank(12);
                o.alu_src_a     = 1'b1;
                o.alu_ct_op     = 5'b01000;
                o.pc_write_cond = 1'b1;
                o.pc_source     = 2'b01;
                push(op, fn, 1'($urandom), o);
            end
            CL_J: begin
                o = blank(13);
                o.pc_write  = 1'b1;
                o.pc_source = 2'b10;
                push(op, fn, 1'($urandom), o);
            end
            default: begin
                o = blank(9);
                o.alu_src_a = 1'b1;
                o.alu_src_b = 2'b10;
                o.alu_ct_op = (cls == CL_ORI) ? 5'b00100 : (cls == CL_LUI) ? 5'b00010 : 5'b00000;
                push(op, fn, 1'($urandom), o);
                o = blank(10);
                o.reg_write = 1'b1;
                push(op, fn, 1'($urandom), o);
            end
        endcase
    endtask

    task automatic addHalt(int n);
        for (int k = 0; k < n; k++) push(6'($urandom), 6'($urandom), 1'($urandom), blank(11));
    endtask

    task automatic newSegment();
        plan.delete();
        stickyIll = 1'b0;
        stickyBus = 1'b0;
        halted    = 1'b0;
        for (int h = 0; h < HOLD; h++) push(6'($urandom), 6'($urandom), 1'($urandom), blank(0));
    endtask

    task automatic applyStimulus(cyc_t c);
        opcode    = c.opcode;
        funct     = c.funct;
        mem_ready = c.ready;
    endtask

    task automatic checkOutput(string name, outs_t exp);
        testsRun++;
        if (dutOut !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h (state got %0d expected %0d)",
                     name, dutOut, exp, dutOut.state_dbg, exp.state_dbg);
        end
    endtask

    task automatic expectValue(string name, int got, int want);
        testsRun++;
        if (got != want) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Ends on a falling edge with reset just released, i.e. at the start of the first IDLE cycle.
    task automatic doReset();
        rst_n     = 1'b0;
        opcode    = 6'($urandom);
        funct     = 6'($urandom);
        mem_ready = 1'($urandom);
        #1;
        checkOutput("reset outputs", '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic runSegment(string tag);
        cntMemWb = 0; cntMemRead = 0; cntIrWrite = 0; cntMemWrite = 0; cntPwc = 0;
        doReset();
        for (int i = 0; i < plan.size(); i++) begin
            applyStimulus(plan[i]);
            #1;
            checkOutput($sformatf("%s cycle%0d", tag, i), plan[i].exp);
            if (reg_write && mem_to_reg) cntMemWb++;
            if (mem_read) cntMemRead++;
            if (ir_write) cntIrWrite++;
            if (mem_write) cntMemWrite++;
            if (pc_write_cond) cntPwc++;
            @(negedge clk);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        #2;

        newSegment();
        addInstr(CL_LW, 0, 0, 6'd0, 6'd0);
        runSegment("lw");
        expectValue("lw memwb pulses", cntMemWb, 1);
        expectValue("lw state after memwb", int'(state_dbg), 1);

        newSegment();
        addInstr(CL_R, 3, 0, 6'b100001, 6'd0);
        runSegment("addu");
        expectValue("addu fetch mem_read cycles", cntMemRead, 4);
        expectValue("addu ir_write pulses", cntIrWrite, 1);

        newSegment();
        addInstr(CL_BEQ, 0, 0, 6'd0, 6'd0);
        addInstr(CL_J, 1, 0, 6'd0, 6'd0);
        addInstr(CL_JR, 0, 0, 6'd0, 6'd0);
        addInstr(CL_ORI, 2, 0, 6'd0, 6'd0);
        addInstr(CL_LUI, 0, 0, 6'd0, 6'd0);
        addInstr(CL_ADDIU, 0, 0, 6'd0, 6'd0);
        runSegment("branch-imm");
        expectValue("beq pc_write_cond pulses", cntPwc, 1);

        newSegment();
        addInstr(CL_ILL, 0, 0, 6'd0, 6'b111111);
        addHalt(20);
        runSegment("illegal");
        expectValue("illegal flag held", int'(illegal_instr), 1);

        newSegment();
        addInstr(CL_SW, 0, 100, 6'd0, 6'd0);
        addHalt(5);
        runSegment("sw timeout");
        expectValue("sw timeout mem_write cycles", cntMemWrite, 16);
        expectValue("bus_err after timeout", int'(bus_err), 1);

        newSegment();
        addInstr(CL_SW, 0, TIMEOUT - 1, 6'd0, 6'd0);
        addInstr(CL_LW, TIMEOUT - 1, TIMEOUT - 1, 6'd0, 6'd0);
        runSegment("ready at limit");
        expectValue("no bus_err at limit", int'(bus_err), 0);

        newSegment();
        addInstr(CL_SW, 0, 3, 6'd0, 6'd0);
        void'(plan.pop_back());
        runSegment("sw abort");
        #1;
        expectValue("mem_write before abort", int'(mem_write), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort outputs", '0);

        for (int s = 0; s < 10; s++) begin
            newSegment();
            for (int n = 0; n < 30; n++) begin
                int r, fw, mw;
                r  = $urandom_range(0, 39);
                fw = ($urandom_range(0, 15) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
                mw = ($urandom_range(0, 15) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
                addInstr((r < 38) ? (r % 9) : CL_ILL, fw, mw, 6'($urandom), 6'd0);
            end
            if (halted) addHalt(4);
            runSegment($sformatf("random%0d", s));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
